servant_uart_rx: RTL
====================

# servant_uart_rx

Parametrised, synthesisable UART receiver that turns the servant SoC's serial output line `q` into framed bytes for bench scoreboards or on-FPGA loop-back checks. It generalises the fixed-rate behavioural decoder with these additions:
- runtime-independent, parameter-set bit timing;
- start-bit glitch rejection;
- framing-error detection;
- a buffered valid/ready byte stream with overflow tracking.

It sits beside `servant_sim`/`servant` on the same `wb_clk` domain.

## Interface
Parameters:
- `DIVISOR`, 280, `wb_clk` cycles per bit (16.129 MHz / 57600); legal range 4..65535
- `DATA_BITS`, 8, data bits per frame; legal range 5..9
- `FIFO_DEPTH`, 4, receive buffer entries; power of two, at least 2

Ports (one clock; reset is synchronous and active-low):
- `wb_clk` in 1, sole clock
- `wb_rst_n` in 1, synchronous active-low reset
- `i_rx` in 1, serial line, idle high, asynchronous to `wb_clk`
- `o_data` out `DATA_BITS`, head-of-buffer byte
- `o_valid` out 1, `o_data` is valid
- `i_ready` in 1, consumer accepts `o_data` when `o_valid & i_ready`
- `o_frame_err` out 1, one-cycle pulse on a bad stop bit
- `o_parity_err` out 1, one-cycle pulse on a parity mismatch (tied 0 without the macro)
- `o_overflow` out 1, sticky: a byte was dropped because the buffer was full
- `i_clr` in 1, clears `o_overflow`

## Operation
- `i_rx` passes through a 2-flop synchronizer, reset to 1. All references to "rx" below mean the synchronized value.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK. Bit counter is `$clog2(DATA_BITS)` wide. Baud counter is 16 bits.
- IDLE: when rx = 0, go to START and load the baud counter with `DIVISOR/2 - 1` (floor).
- START: when the counter reaches 0, sample rx.
  - rx = 1: glitch; return to IDLE with no flag.
  - rx = 0: go to DATA and load `DIVISOR - 1`.
- DATA: sample at each counter expiry and reload `DIVISOR - 1`. Bits arrive LSB first into a shift register. After `DATA_BITS` samples go to PARITY or STOP.
- PARITY: sample one bit and compare with even parity over the data. On mismatch, pulse `o_parity_err` at the STOP sample and discard the byte.
- STOP: sample once.
  - rx = 1 and parity ok: push the byte; go to IDLE.
  - rx = 0: pulse `o_frame_err`, discard the byte, go to BREAK.
- BREAK: wait for rx = 1, then go to IDLE. A held-low line never produces repeated frames.
- Buffer is first-word fall-through: `o_data`/`o_valid` reflect the head entry.
  - Pop on `o_valid & i_ready`.
  - Push while full and not popping in the same cycle: drop the byte and set `o_overflow`.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push and pop in the same cycle when empty: not possible (see Timing).
- `o_overflow` stays set until a cycle with `i_clr` = 1. If `i_clr` and a new overflow occur in the same cycle, overflow wins.
- Pointers wrap modulo `FIFO_DEPTH`. Count is `$clog2(FIFO_DEPTH)+1` bits.

## Timing
- Cycle 0 is the first cycle rx = 0 is seen in IDLE. This is 2 cycles after `i_rx` falls.
- Sample points:
  - start bit: cycle `DIVISOR/2`;
  - data bit k: cycle `DIVISOR/2 + (k+1)*DIVISOR`;
  - parity bit (macro only): cycle `DIVISOR/2 + (DATA_BITS+1)*DIVISOR`;
  - stop bit: one `DIVISOR` after the last data or parity bit.
- `o_valid` rises in the cycle after the stop sample (registered push). Defaults with no parity: stop sampled at cycle 2660, `o_valid` at 2661.
- Error pulses are asserted in the cycle after the stop sample, for exactly 1 cycle.
- IDLE can detect a new start in the cycle after STOP. Back-to-back frames with no extra idle time are received.
- Reset values while `wb_rst_n` = 0 (taking effect at the next edge, including mid-frame):
  - FSM in IDLE, synchronizer at 1, buffer empty;
  - `o_valid`, `o_frame_err`, `o_parity_err`, `o_overflow` = 0;
  - `o_data` = 0.
- A partially received frame is lost on reset. The first frame after reset is received correctly if its start edge falls after reset release.

## Configuration
- `SERVANT_UART_RX_PARITY_EN` defined:
  - the PARITY state exists; frames are start + `DATA_BITS` + even parity + stop;
  - `o_parity_err` is driven.
- Not defined:
  - the PARITY state is compiled out; frames are 8N1-style (start, `DATA_BITS`, stop);
  - `o_parity_err` is constant 0.

## Structure
- Package `servant_uart_pkg` holds:
  - the FSM state enum `uart_rx_state_t`;
  - localparam `SYNC_STAGES = 2`;
  - the baud-counter width constant.
- Sub-module `servant_uart_fifo` is the parametrised first-word fall-through buffer. Parameters: `WIDTH`, `DEPTH`. It has push/pop/full/empty and reuses `wb_clk`/`wb_rst_n`.
- The top level contains the synchronizer, FSM, counters, shift register and flag logic.

## Test plan
- Send 0x55 then 0xA3 back-to-back at `DIVISOR` = 280 with `i_ready` = 1 -> `o_data` 0x55 with `o_valid` at cycle 2661, then 0xA3 exactly 2800 cycles later; no flags.
- Drive `i_rx` low for 10 cycles, then high -> no `o_valid` and no flags; the next 0x3C frame is received correctly.
- Send 0x7E with the stop bit forced 0 and the line held low 5000 cycles -> one `o_frame_err` pulse, no push; after the line rises, 0x12 is received.
- With `i_ready` = 0 and `FIFO_DEPTH` = 4, send 0x01..0x05 -> `o_overflow` = 1 after the 5th frame. Then raise `i_ready`: pops are 0x01..0x04 in order and `o_valid` then falls. Pulsing `i_clr` clears `o_overflow`.
- Assert `wb_rst_n` = 0 for 3 cycles at cycle 1500 of a frame -> all outputs 0 next cycle, buffer empty; a subsequent 0xC9 frame is received correctly.
- With the macro defined, send 0x0F with the parity bit = 1 -> `o_parity_err` pulse, no push. Send 0x0F with the parity bit = 0 -> 0x0F delivered.

Source files
------------

// File: rtl/servant_uart_pkg.sv
// Shared types and constants for the servant UART receiver.
// Optional feature macro: SERVANT_UART_RX_PARITY_EN (adds the PARITY state).
package servant_uart_pkg;
  localparam int SYNC_STAGES = 2;
  localparam int BAUD_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef SERVANT_UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } uart_rx_state_t;
endpackage

// File: rtl/servant_uart_fifo.sv
// First-word fall-through receive buffer; head entry is visible while non-empty.
module servant_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_q];

  always_ff @(posedge wb_clk)
    if (do_push) mem[wr_q] <= wdata;

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/servant_uart_rx.sv
// UART receiver for the servant serial line: sync, frame FSM, FWFT byte buffer.
// Optional feature macro: SERVANT_UART_RX_PARITY_EN (even parity bit before stop).
module servant_uart_rx
  import servant_uart_pkg::*;
#(
  parameter int DIVISOR    = 280,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overflow,
  input  logic                 i_clr
);
  localparam int BCNT_W = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] HALF_CNT = BAUD_W'(DIVISOR/2 - 1);
  localparam logic [BAUD_W-1:0] FULL_CNT = BAUD_W'(DIVISOR - 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_BITS - 1);

  uart_rx_state_t         state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx;
  logic [BAUD_W-1:0]      cnt_q, cnt_val;
  logic [BCNT_W-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   tick, cnt_ld, shift_en, push, pop, full, empty, ferr_d;

  assign rx   = sync_q[SYNC_STAGES-1];
  assign tick = (cnt_q == '0);

  always_ff @(posedge wb_clk)
    if (!wb_rst_n) sync_q <= '1;
    else           sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};

  always_ff @(posedge wb_clk)
    if (!wb_rst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;

`ifdef SERVANT_UART_RX_PARITY_EN
  logic par_smp, par_bad_q, perr_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_ld   = 1'b0;
    cnt_val  = FULL_CNT;
    shift_en = 1'b0;
    push     = 1'b0;
    ferr_d   = 1'b0;
`ifdef SERVANT_UART_RX_PARITY_EN
    par_smp  = 1'b0;
    perr_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: if (!rx) begin
        state_d = ST_START;
        cnt_ld  = 1'b1;
        cnt_val = HALF_CNT;
      end
      // Mid-start-bit recheck rejects short low glitches.
      ST_START: if (tick) begin
        state_d = rx ? ST_IDLE : ST_DATA;
        cnt_ld  = ~rx;
      end
      ST_DATA: if (tick) begin
        shift_en = 1'b1;
        cnt_ld   = 1'b1;
`ifdef SERVANT_UART_RX_PARITY_EN
        if (bit_cnt_q == LAST_BIT) state_d = ST_PARITY;
`else
        if (bit_cnt_q == LAST_BIT) state_d = ST_STOP;
`endif
      end
`ifdef SERVANT_UART_RX_PARITY_EN
      ST_PARITY: if (tick) begin
        par_smp = 1'b1;
        cnt_ld  = 1'b1;
        state_d = ST_STOP;
      end
`endif
      ST_STOP: if (tick) begin
        state_d = rx ? ST_IDLE : ST_BREAK;
        ferr_d  = ~rx;
`ifdef SERVANT_UART_RX_PARITY_EN
        perr_d  = par_bad_q;
        push    = rx & ~par_bad_q;
`else
        push    = rx;
`endif
      end
      ST_BREAK: if (rx) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      if (cnt_ld)          cnt_q <= cnt_val;
      else if (cnt_q != 0) cnt_q <= cnt_q - BAUD_W'(1);
      if (state_q != ST_DATA) bit_cnt_q <= '0;
      else if (shift_en)      bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
      if (shift_en) shift_q <= {rx, shift_q[DATA_BITS-1:1]};
    end
  end

`ifdef SERVANT_UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  always_ff @(posedge wb_clk)
    if (!wb_rst_n) begin
      par_bad_q    <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      if (par_smp) par_bad_q <= (^shift_q) ^ rx;
      o_parity_err <= perr_d;
    end
`else
  assign o_parity_err = 1'b0;
`endif

  always_ff @(posedge wb_clk)
    if (!wb_rst_n) o_frame_err <= 1'b0;
    else           o_frame_err <= ferr_d;

  assign pop     = o_valid & i_ready;
  assign o_valid = ~empty;

  // A new drop takes priority over a clear in the same cycle.
  always_ff @(posedge wb_clk)
    if (!wb_rst_n)                o_overflow <= 1'b0;
    else if (push & full & ~pop) o_overflow <= 1'b1;
    else if (i_clr)              o_overflow <= 1'b0;

  servant_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .push     (push),
    .pop      (pop),
    .wdata    (shift_q),
    .rdata    (o_data),
    .full     (full),
    .empty    (empty)
  );
endmodule
